// File: rtl/mpi_rx_credit_buffer.sv
// mpi_rx_credit_buffer
// Credit-based receive FIFO sitting directly downstream of sender_mpi.
// Flits pushed on valid_i/data_i are buffered in a DEPTH-entry circular FIFO
// and presented to the local consumer over valid_o/ready_i. Every drained entry
// returns one registered yummy_o credit pulse to the sender, whose credit
// counter starts at DEPTH, so a well-behaved sender can never overrun us.
// A flit arriving into a full FIFO (no same-cycle dequeue) is dropped and
// latches the sticky overflow_o flag.

module mpi_rx_credit_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic                     yummy_o,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Registered state and next-state values
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              yummy_q, yummy_d;
    logic              overflow_q, overflow_d;

    // Storage, flattened so each entry is driven from its own generate scope
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_flat;

    // Handshake decodes
    logic empty;
    logic full;
    logic enq;
    logic deq;
    logic drop;

    // Decide what happens this cycle: dequeue, enqueue and overflow drop.
    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_COUNT);
        deq   = !empty && ready_i;
        enq   = valid_i && (!full || deq);
        drop  = valid_i && full && !deq;
    end

    // Next-state for pointers, occupancy, credit pulse and sticky overflow.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        yummy_d    = deq;
        overflow_d = overflow_q | drop;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset discards buffered flits and pending credits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            yummy_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            yummy_q    <= yummy_d;
            overflow_q <= overflow_d;
        end
    end

    // One register per FIFO entry; entries are cleared on reset so data_o
    // reads zero out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_q;
            logic [DATA_WIDTH-1:0] entry_d;

            // Capture the incoming flit when this entry is the write target
            always_comb begin
                entry_d = entry_q;
                if (enq && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = data_i;
                end
            end

            // Entry storage register
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign mem_flat[gi] = entry_q;
        end
    endgenerate

    // Outputs come straight from registered state; the head read is a mux,
    // so there is no same-cycle bypass from data_i to data_o.
    assign valid_o    = !empty;
    assign data_o     = mem_flat[rd_ptr_q];
    assign count_o    = count_q;
    assign yummy_o    = yummy_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_mpi_rx_credit_buffer.sv
// Testbench for mpi_rx_credit_buffer (DATA_WIDTH=64, DEPTH=4).
// A queue model acts as scoreboard: accepted flits are pushed when driven and
// compared against data_o as the consumer drains them. A table of per-cycle
// vectors with hand-derived expected outputs covers the directed scenarios.

module tb_mpi_rx_credit_buffer;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          ready_i = 1'b0;
    logic          yummy_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic [2:0]    count_o;
    logic          overflow_o;

    always #5 clk = ~clk;

    mpi_rx_credit_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .yummy_o    (yummy_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    // Scoreboard / model state
    logic [DW-1:0] sb_q[$];
    bit            ovf_m;
    bit            yum_m;
    int            total;
    int            bad;
    int            yummy_seen;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [2:0]    e_count;
        logic          e_yummy;
        logic          e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the edge, compare at the falling edge,
    // then advance the model by what the next rising edge will do.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        bit deq_m;
        bit full_m;
        @(posedge clk);
        #1;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        @(negedge clk);
        check("sb_valid", DW'(valid_o), DW'(sb_q.size() != 0));
        if (sb_q.size() != 0) check("sb_data", data_o, sb_q[0]);
        check("sb_count", DW'(count_o), DW'(sb_q.size()));
        check("sb_overflow", DW'(overflow_o), DW'(ovf_m));
        check("sb_yummy", DW'(yummy_o), DW'(yum_m));
        if (yummy_o === 1'b1) yummy_seen++;
        full_m = (sb_q.size() == DEPTH);
        deq_m  = (sb_q.size() != 0) && r;
        if (deq_m) begin
            $display("deq data=%h count=%0d", sb_q[0], sb_q.size());
            void'(sb_q.pop_front());
        end
        if (v) begin
            if (!full_m || deq_m) sb_q.push_back(d);
            else ovf_m = 1'b1;
        end
        yum_m = deq_m;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_i = 1'b0;
        sb_q.delete();
        ovf_m = 1'b0;
        yum_m = 1'b0;
        $display("reset released after %0d cycles", n);
    endtask

    task automatic add(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic ev, input logic [DW-1:0] ed, input logic [2:0] ec,
                       input logic ey, input logic eo);
        vec_t t;
        t.v = v; t.d = d; t.r = r;
        t.e_valid = ev; t.e_data = ed; t.e_count = ec; t.e_yummy = ey; t.e_ovf = eo;
        vecs.push_back(t);
    endtask

    initial begin
        int credits;
        int sent;
        logic r_tog;
        logic v_now;

        total = 0;
        bad   = 0;
        ovf_m = 1'b0;
        yum_m = 1'b0;

        // Directed vectors: inputs, then outputs observed in that same cycle
        // Single flit
        add(1, 64'hDEAD_BEEF_0000_0001, 1, 0, '0, 0, 0, 0);
        add(0, '0, 1, 1, 64'hDEAD_BEEF_0000_0001, 1, 0, 0);
        add(0, '0, 0, 0, '0, 0, 1, 0);
        add(0, '0, 0, 0, '0, 0, 0, 0);
        // Fill 1..4 then drain
        add(1, 64'd1, 0, 0, '0,    0, 0, 0);
        add(1, 64'd2, 0, 1, 64'd1, 1, 0, 0);
        add(1, 64'd3, 0, 1, 64'd1, 2, 0, 0);
        add(1, 64'd4, 0, 1, 64'd1, 3, 0, 0);
        add(0, '0,    0, 1, 64'd1, 4, 0, 0);
        add(0, '0,    1, 1, 64'd1, 4, 0, 0);
        add(0, '0,    1, 1, 64'd2, 3, 1, 0);
        add(0, '0,    1, 1, 64'd3, 2, 1, 0);
        add(0, '0,    1, 1, 64'd4, 1, 1, 0);
        add(0, '0,    0, 0, '0,    0, 1, 0);
        add(0, '0,    0, 0, '0,    0, 0, 0);
        // Full with simultaneous enqueue and dequeue
        add(1, 64'd1, 0, 0, '0,    0, 0, 0);
        add(1, 64'd2, 0, 1, 64'd1, 1, 0, 0);
        add(1, 64'd3, 0, 1, 64'd1, 2, 0, 0);
        add(1, 64'd4, 0, 1, 64'd1, 3, 0, 0);
        add(1, 64'd5, 1, 1, 64'd1, 4, 0, 0);
        add(0, '0,    1, 1, 64'd2, 4, 1, 0);
        add(0, '0,    1, 1, 64'd3, 3, 1, 0);
        add(0, '0,    1, 1, 64'd4, 2, 1, 0);
        add(0, '0,    1, 1, 64'd5, 1, 1, 0);
        add(0, '0,    0, 0, '0,    0, 1, 0);
        // Overflow: full, no dequeue, flit 9 dropped
        add(1, 64'h11, 0, 0, '0,     0, 0, 0);
        add(1, 64'h12, 0, 1, 64'h11, 1, 0, 0);
        add(1, 64'h13, 0, 1, 64'h11, 2, 0, 0);
        add(1, 64'h14, 0, 1, 64'h11, 3, 0, 0);
        add(1, 64'h9,  0, 1, 64'h11, 4, 0, 0);
        add(0, '0,     0, 1, 64'h11, 4, 0, 1);
        add(0, '0,     1, 1, 64'h11, 4, 0, 1);
        add(0, '0,     1, 1, 64'h12, 3, 1, 1);
        add(0, '0,     1, 1, 64'h13, 2, 1, 1);
        add(0, '0,     1, 1, 64'h14, 1, 1, 1);
        add(0, '0,     0, 0, '0,     0, 1, 1);
        add(0, '0,     0, 0, '0,     0, 0, 1);

        // Reset then idle: all outputs zero, no credit pulses
        do_reset(2);
        yummy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, '0, 0);
            check("idle_data", data_o, '0);
        end
        check("idle_yummy_count", DW'(yummy_seen), '0);

        // Table-driven directed scenarios
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].r);
            check($sformatf("vec%0d_valid", i), DW'(valid_o), DW'(vecs[i].e_valid));
            if (vecs[i].e_valid) check($sformatf("vec%0d_data", i), data_o, vecs[i].e_data);
            check($sformatf("vec%0d_count", i), DW'(count_o), DW'(vecs[i].e_count));
            check($sformatf("vec%0d_yummy", i), DW'(yummy_o), DW'(vecs[i].e_yummy));
            check($sformatf("vec%0d_overflow", i), DW'(overflow_o), DW'(vecs[i].e_ovf));
        end

        // Wrap-around stream from a credit-respecting sender, ready toggling
        do_reset(1);
        credits    = DEPTH;
        sent       = 0;
        yummy_seen = 0;
        r_tog      = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (sent == 10 && sb_q.size() == 0 && yummy_seen == 10) break;
            v_now = (sent < 10) && (credits > 0);
            step(v_now, 64'h100 + 64'(sent), r_tog);
            credits = credits - int'(v_now) + int'(yummy_o === 1'b1);
            sent    = sent + int'(v_now);
            r_tog   = !r_tog;
        end
        check("stream_sent", DW'(sent), DW'(10));
        check("stream_yummy_count", DW'(yummy_seen), DW'(10));
        check("stream_credits", DW'(credits), DW'(DEPTH));
        check("stream_overflow", DW'(overflow_o), '0);

        // Mid-stream reset with 3 entries buffered and a credit pending
        for (int i = 0; i < 4; i++) step(1, 64'h200 + 64'(i), 0);
        step(0, '0, 1);
        check("pre_reset_count", DW'(count_o), DW'(4));
        do_reset(1);
        yummy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 1);
            check("post_reset_data", data_o, '0);
        end
        check("post_reset_yummy_count", DW'(yummy_seen), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
